// File: rtl/bp_cce_alu_issue.sv
// bp_cce_alu_issue: one-deep issue/writeback stage driving the combinational CCE ALU
module bp_cce_alu_issue #(
   parameter int width_p = 16,
   parameter int num_gpr_p = 8,
   localparam int gpr_id_width_lp = $clog2(num_gpr_p)
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       inst_v_i,
   output logic                       inst_ready_o,
   input  logic [3:0]                 inst_op_i,
   input  logic [gpr_id_width_lp-1:0] inst_src_a_i,
   input  logic                       inst_src_b_imm_i,
   input  logic [gpr_id_width_lp-1:0] inst_src_b_i,
   input  logic [width_p-1:0]         inst_imm_i,
   input  logic [gpr_id_width_lp-1:0] inst_dst_i,
   output logic [width_p-1:0]         alu_opd_a_o,
   output logic [width_p-1:0]         alu_opd_b_o,
   output logic [3:0]                 alu_op_o,
   input  logic [width_p-1:0]         alu_res_i,
   output logic                       res_v_o,
   input  logic                       res_ready_i,
   output logic [gpr_id_width_lp-1:0] res_dst_o,
   output logic [width_p-1:0]         res_data_o,
   output logic                       res_zero_o,
   input  logic [gpr_id_width_lp-1:0] dbg_addr_i,
   output logic [width_p-1:0]         dbg_data_o
);
   localparam logic [3:0] e_add_op = 4'd0;
   logic                       s1_v_q, s1_v_d;
   logic [3:0]                 s1_op_q, s1_op_d;
   logic [width_p-1:0]         s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [gpr_id_width_lp-1:0] s1_dst_q, s1_dst_d;
   logic [width_p-1:0]         gpr_q [num_gpr_p];
   logic [width_p-1:0]         gpr_d [num_gpr_p];
   logic                       accept, fire;
   logic [width_p-1:0]         fwd_a, fwd_b;
   // Handshakes, forwarding of the retiring result, writeback and S1 next state
   always_comb begin
      inst_ready_o = ~s1_v_q | res_ready_i;
      accept = inst_v_i & inst_ready_o;
      fire = s1_v_q & res_ready_i;
      fwd_a = (fire && s1_dst_q == inst_src_a_i) ? alu_res_i : gpr_q[inst_src_a_i];
      fwd_b = (fire && s1_dst_q == inst_src_b_i) ? alu_res_i : gpr_q[inst_src_b_i];
      gpr_d = gpr_q;
      if (fire) gpr_d[s1_dst_q] = alu_res_i;
      s1_v_d = accept ? 1'b1 : (fire ? 1'b0 : s1_v_q);
      s1_op_d = accept ? inst_op_i : s1_op_q;
      s1_a_d = accept ? fwd_a : s1_a_q;
      s1_b_d = accept ? (inst_src_b_imm_i ? inst_imm_i : fwd_b) : s1_b_q;
      s1_dst_d = accept ? inst_dst_i : s1_dst_q;
   end
   // ALU drive and result presentation, quiet (zero / add) while S1 is empty
   always_comb begin
      alu_opd_a_o = s1_v_q ? s1_a_q : '0;
      alu_opd_b_o = s1_v_q ? s1_b_q : '0;
      alu_op_o = s1_v_q ? s1_op_q : e_add_op;
      res_v_o = s1_v_q;
      res_dst_o = s1_v_q ? s1_dst_q : '0;
      res_data_o = alu_res_i;
      res_zero_o = (alu_res_i == '0);
      dbg_data_o = gpr_q[dbg_addr_i];
   end
   // State registers; reset drops any in-flight result and clears the GPRs
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_v_q <= 1'b0;
         s1_op_q <= e_add_op;
         s1_a_q <= '0;
         s1_b_q <= '0;
         s1_dst_q <= '0;
         gpr_q <= '{default: '0};
      end else begin
         s1_v_q <= s1_v_d;
         s1_op_q <= s1_op_d;
         s1_a_q <= s1_a_d;
         s1_b_q <= s1_b_d;
         s1_dst_q <= s1_dst_d;
         gpr_q <= gpr_d;
      end
   end
endmodule
